negate_rr_arbiter: RTL

- Shares one WIDTH-bit two's-complement negation datapath among NREQ requesters.
- Round-robin arbitration, one registered response slot, valid/ready handshakes on both sides.
- Sits between several arithmetic clients (e.g. subtract-via-add paths in the CLA) and a single negation unit, so the unit is not replicated per client.

---
 rtl/negate_rr_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/negate_rr_arbiter.sv
// -----------------------------------------------------------------------------
// negate_rr_arbiter
//   Shares a single WIDTH-bit two's-complement negation datapath among NREQ
//   requesters. A round-robin pointer picks the next requester whenever the
//   one-entry response register is free. The register is free when it is empty,
//   or when it is full and being drained in the same cycle. The result of an
//   accepted operand appears on the response port one cycle after acceptance.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req_valid  in   [NREQ]        requester i presents an operand
//   req_data   in   [NREQ*WIDTH]  operand i in bits [i*WIDTH +: WIDTH]
//   req_ready  out  [NREQ]        one-hot (or zero) acceptance this cycle
//   rsp_valid  out  1             response register holds a result
//   rsp_ready  in   1             consumer takes the response this cycle
//   rsp_data   out  [WIDTH]       negated operand
//   rsp_id     out  [IDW]         index of the requester behind rsp_data
//   rsp_ovf    out  1             operand was the most-negative value
//                                 (present only with NEG_OVF_FLAG_EN)
//
// Build option
//   NEG_OVF_FLAG_EN : when defined, adds the rsp_ovf output.
// -----------------------------------------------------------------------------
module negate_rr_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 16,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
`ifdef NEG_OVF_FLAG_EN
  output logic                    rsp_ovf,
`endif
  output logic [IDW-1:0]          rsp_id
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_rsp_data;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_ovf;

  logic             w_slot_free;
  logic             w_grant;
  logic             w_found;
  logic [IDW-1:0]   w_grant_idx;
  logic [IDW-1:0]   w_scan_idx;
  logic [WIDTH-1:0] w_operand;
  logic [WIDTH-1:0] w_negated;
  logic             w_is_min;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Free slot: empty, or full and being drained this very cycle.
  assign w_slot_free = (r_state == ST_EMPTY) || rsp_ready;

  // Round-robin scan: first pending requester at or after the pointer, wrapping.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(r_ptr) + k;
      j = (j >= NREQ) ? (j - NREQ) : j;
      w_scan_idx = IDW'(j);
      if (!w_found && req_valid[w_scan_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan_idx;
      end else begin
        w_found     = w_found;
      end
    end
  end

  // A grant needs a pending request, a free slot and no reset in progress.
  assign w_grant   = w_found && w_slot_free && !reset;
  assign req_ready = w_grant ? (NREQ'(1) << w_grant_idx) : '0;

  // Operand mux for the granted requester.
  always_comb begin
    w_operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_operand = (w_grant_idx == IDW'(i)) ? req_data[i*WIDTH +: WIDTH] : w_operand;
    end
  end

  assign w_negated = ~w_operand + WIDTH'(1);
  assign w_is_min  = (w_operand == MOST_NEG);

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot next-state: a grant always refills; a drain without grant empties.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_grant ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (w_grant) begin
          w_state_nxt = ST_FULL;
        end else if (rsp_ready) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Response payload and priority pointer; payload holds unless a grant loads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_rsp_ovf  <= 1'b0;
      r_ptr      <= '0;
    end else if (w_grant) begin
      r_rsp_data <= w_negated;
      r_rsp_id   <= w_grant_idx;
      r_rsp_ovf  <= w_is_min;
      r_ptr      <= (w_grant_idx == IDW'(NREQ-1)) ? '0 : (w_grant_idx + IDW'(1));
    end else begin
      r_rsp_data <= r_rsp_data;
      r_rsp_id   <= r_rsp_id;
      r_rsp_ovf  <= r_rsp_ovf;
      r_ptr      <= r_ptr;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

`ifdef NEG_OVF_FLAG_EN
  assign rsp_ovf = r_rsp_ovf;
`else
  // Flag register is only observable when the option is built in.
  logic w_unused_ovf;
  assign w_unused_ovf = r_rsp_ovf;
`endif

endmodule
